// File: rtl/fridge_pkg.sv
// rtl/fridge_pkg.sv - shared widths and state encoding for the fridge thermostat
package fridge_pkg;

    localparam int TEMP_W     = 5;
    localparam int TICK_CNT_W = 16;

    typedef enum logic [1:0] {
        OFF_WAIT = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2,
        DEFROST  = 2'd3
    } thermo_state_t;

endpackage

// File: rtl/thermo_channel.sv
// rtl/thermo_channel.sv - per-compartment cooling demand latch with hysteresis
module thermo_channel
    import fridge_pkg::*;
#(
    parameter int HYST = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwr,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic [TEMP_W-1:0] sense,
    output logic              dem
);

    localparam int CMP_W = TEMP_W + 1;
    localparam logic [CMP_W-1:0] HYST_C = CMP_W'(HYST);

    logic [CMP_W-1:0] set_level;
    logic             set_hit;
    logic             clr_hit;

    // One extra bit so a high setpoint plus hysteresis cannot wrap to a low threshold.
    assign set_level = {1'b0, setpoint} + HYST_C;
    assign set_hit   = ({1'b0, sense} >= set_level);
    assign clr_hit   = (sense <= setpoint);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dem <= 1'b0;
        end else if (!pwr) begin
            dem <= 1'b0;
        end else if (set_hit) begin
            dem <= 1'b1;
        end else if (clr_hit) begin
            dem <= 1'b0;
        end
    end

endmodule

// File: rtl/fridge_thermostat.sv
// rtl/fridge_thermostat.sv - compressor/damper/defrost controller; defrost enabled by THERMO_DEFROST_EN
module fridge_thermostat
    import fridge_pkg::*;
#(
    parameter int HYST             = 2,
    parameter int MIN_ON           = 60,
    parameter int MIN_OFF          = 120,
    parameter int DEFROST_INTERVAL = 480,
    parameter int DEFROST_LEN      = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              fgp,
    input  logic              frp,
    input  logic [TEMP_W-1:0] fgt,
    input  logic [TEMP_W-1:0] frt,
    input  logic [TEMP_W-1:0] fg_sense,
    input  logic [TEMP_W-1:0] fr_sense,
    output logic              comp_on,
    output logic              fg_damper,
    output logic              fr_damper,
    output logic              defrost_on,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_OFF_WAIT = OFF_WAIT;
    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_DEFROST  = DEFROST;

    localparam logic [TICK_CNT_W-1:0] MIN_ON_C  = TICK_CNT_W'(MIN_ON);
    localparam logic [TICK_CNT_W-1:0] MIN_OFF_C = TICK_CNT_W'(MIN_OFF);

    logic                  fg_dem;
    logic                  fr_dem;
    logic                  any_dem;
    logic [1:0]            state_d;
    logic [TICK_CNT_W-1:0] cnt;
    logic [TICK_CNT_W-1:0] cnt_d;
    logic [TICK_CNT_W-1:0] cnt_inc;

    thermo_channel #(.HYST(HYST)) u_fg_channel (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwr      (fgp),
        .setpoint (fgt),
        .sense    (fg_sense),
        .dem      (fg_dem)
    );

    thermo_channel #(.HYST(HYST)) u_fr_channel (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwr      (frp),
        .setpoint (frt),
        .sense    (fr_sense),
        .dem      (fr_dem)
    );

    assign any_dem = fg_dem | fr_dem;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef THERMO_DEFROST_EN
    localparam logic [TICK_CNT_W-1:0] DEF_INT_C = TICK_CNT_W'(DEFROST_INTERVAL);
    localparam logic [TICK_CNT_W-1:0] DEF_LEN_C = TICK_CNT_W'(DEFROST_LEN);

    logic [TICK_CNT_W-1:0] run_acc;
    logic [TICK_CNT_W-1:0] run_acc_d;
    logic [TICK_CNT_W-1:0] run_acc_inc;

    assign run_acc_inc = (run_acc >= DEF_INT_C) ? run_acc : run_acc + 1'b1;
`else
    logic unused_defrost_cfg;
    assign unused_defrost_cfg = ^{DEFROST_INTERVAL, DEFROST_LEN};
`endif

    // Timed exits compare the post-increment count, so a state lasts exactly N ticks.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
`ifdef THERMO_DEFROST_EN
        run_acc_d = run_acc;
`endif
        case (state)
            ST_OFF_WAIT: begin
                if (tick) begin
                    if (cnt_inc >= MIN_OFF_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_IDLE: begin
                if (any_dem) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    cnt_d = cnt_inc;
`ifdef THERMO_DEFROST_EN
                    run_acc_d = run_acc_inc;
                    if ((cnt_inc >= MIN_ON_C) && (run_acc_inc == DEF_INT_C)) begin
                        state_d = ST_DEFROST;
                        cnt_d   = '0;
                    end else
`endif
                    if ((cnt_inc >= MIN_ON_C) && !any_dem) begin
                        state_d = ST_OFF_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DEFROST: begin
`ifdef THERMO_DEFROST_EN
                if (tick) begin
                    if (cnt_inc >= DEF_LEN_C) begin
                        state_d   = ST_OFF_WAIT;
                        cnt_d     = '0;
                        run_acc_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`else
                state_d = ST_OFF_WAIT;
                cnt_d   = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF_WAIT;
            cnt   <= '0;
`ifdef THERMO_DEFROST_EN
            run_acc <= '0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
`ifdef THERMO_DEFROST_EN
            run_acc <= run_acc_d;
`endif
        end
    end

    assign comp_on   = (state == ST_RUN);
    assign fg_damper = comp_on & fg_dem;
    assign fr_damper = comp_on & fr_dem;
`ifdef THERMO_DEFROST_EN
    assign defrost_on = (state == ST_DEFROST);
`else
    assign defrost_on = 1'b0;
`endif

endmodule

// File: tb/tb_fridge_thermostat.sv
// tb/tb_fridge_thermostat.sv - randomized bench against a tick-countdown reference model
module tb_fridge_thermostat;

    localparam int HYST    = 2;
    localparam int MIN_ON  = 3;
    localparam int MIN_OFF = 4;
    localparam int DEF_INT = 10;
    localparam int DEF_LEN = 2;
`ifdef THERMO_DEFROST_EN
    localparam bit DEF_EN = 1'b1;
`else
    localparam bit DEF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       fgp;
    logic       frp;
    logic [4:0] fgt;
    logic [4:0] frt;
    logic [4:0] fg_sense;
    logic [4:0] fr_sense;
    logic       comp_on;
    logic       fg_damper;
    logic       fr_damper;
    logic       defrost_on;
    logic [1:0] state;

    always #5 clk = ~clk;

    fridge_thermostat #(
        .HYST             (HYST),
        .MIN_ON           (MIN_ON),
        .MIN_OFF          (MIN_OFF),
        .DEFROST_INTERVAL (DEF_INT),
        .DEFROST_LEN      (DEF_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .fgp        (fgp),
        .frp        (frp),
        .fgt        (fgt),
        .frt        (frt),
        .fg_sense   (fg_sense),
        .fr_sense   (fr_sense),
        .comp_on    (comp_on),
        .fg_damper  (fg_damper),
        .fr_damper  (fr_damper),
        .defrost_on (defrost_on),
        .state      (state)
    );

    int n_cmp;
    int n_bad;
    int tcnt;

    // Reference: mode 0 rest, 1 idle, 2 run, 3 defrost; timers count down remaining ticks.
    int m_mode;
    int m_left;
    int m_run;
    int m_acc;
    bit m_fg;
    bit m_fr;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit next_dem(input bit cur, input bit pwr, input int sp, input int s);
        if (!pwr) return 1'b0;
        if (s >= sp + HYST) return 1'b1;
        if (s <= sp) return 1'b0;
        return cur;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_left = MIN_OFF;
        m_run  = 0;
        m_acc  = 0;
        m_fg   = 1'b0;
        m_fr   = 1'b0;
    endtask

    task automatic model_step();
        bit anyd;
        anyd = m_fg | m_fr;
        case (m_mode)
            0: if (tick) begin
                m_left--;
                if (m_left == 0) m_mode = 1;
            end
            1: if (anyd) begin
                m_mode = 2;
                m_run  = 0;
            end
            2: if (tick) begin
                m_run++;
                if (m_acc < DEF_INT) m_acc++;
                if (m_run >= MIN_ON) begin
                    if (DEF_EN && m_acc == DEF_INT) begin
                        m_mode = 3;
                        m_left = DEF_LEN;
                    end else if (!anyd) begin
                        m_mode = 0;
                        m_left = MIN_OFF;
                    end
                end
            end
            default: if (tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0;
                    m_left = MIN_OFF;
                    m_acc  = 0;
                end
            end
        endcase
        m_fg = next_dem(m_fg, fgp, int'(fgt), int'(fg_sense));
        m_fr = next_dem(m_fr, frp, int'(frt), int'(fr_sense));
    endtask

    task automatic compare_outputs();
        check("comp_on",    comp_on,    m_mode == 2);
        check("fg_damper",  fg_damper,  (m_mode == 2) && m_fg);
        check("fr_damper",  fr_damper,  (m_mode == 2) && m_fr);
        check("defrost_on", defrost_on, m_mode == 3);
        check("state",      state,      m_mode);
    endtask

    task automatic step();
        tick = (tcnt == 3);
        tcnt = (tcnt + 1) % 4;
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic wait_mode(input int target, input int bound);
        int k;
        k = 0;
        while (m_mode != target && k < bound) begin
            step();
            k++;
        end
        if (m_mode != target) check("wait_mode", m_mode, target);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_state",   state,      0);
        check("async_comp",    comp_on,    0);
        check("async_defrost", defrost_on, 0);
        check("async_fg_dmp",  fg_damper,  0);
        check("async_fr_dmp",  fr_damper,  0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick  = 1'b0;
    endtask

    initial begin
        int v;
        int r;
        n_cmp    = 0;
        n_bad    = 0;
        tcnt     = 0;
        rst_n    = 1'b0;
        tick     = 1'b0;
        fgp      = 1'b1;
        fgt      = 5'd10;
        fg_sense = 5'd15;
        frp      = 1'b0;
        frt      = 5'd0;
        fr_sense = 5'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // power-up rest then fridge run
        repeat (40) step();

        // hysteresis band
        fg_sense = 5'd10;
        repeat (40) step();
        fg_sense = 5'd11;
        repeat (12) step();
        fg_sense = 5'd12;
        repeat (12) step();
        fg_sense = 5'd11;
        repeat (20) step();
        fg_sense = 5'd10;
        repeat (30) step();

        // short demand pulse against minimum run
        fg_sense = 5'd12;
        repeat (4) step();
        fg_sense = 5'd10;
        repeat (40) step();

        // continuous freezer demand through defrost cycles
        fgp      = 1'b0;
        frp      = 1'b1;
        frt      = 5'd5;
        fr_sense = 5'd20;
        repeat (120) step();
        fr_sense = 5'd5;
        repeat (30) step();

        // power bit drop during run
        fr_sense = 5'd20;
        wait_mode(2, 200);
        repeat (4) step();
        frp = 1'b0;
        repeat (30) step();
        frp = 1'b1;

        // async reset while the heater (or compressor) is driven
        wait_mode(DEF_EN ? 3 : 2, 400);
        step();
        async_reset();

        // setpoint at the top of the range never raises demand
        fgp      = 1'b1;
        fgt      = 5'd31;
        fg_sense = 5'd31;
        frp      = 1'b0;
        repeat (30) step();

        repeat (3000) begin
            r = $urandom_range(0, 15);
            case (r)
                0: fgp = 1'($urandom);
                1: frp = 1'($urandom);
                2: fgt = 5'($urandom_range(0, 31));
                3: frt = 5'($urandom_range(0, 31));
                4: fg_sense = 5'($urandom_range(0, 31));
                5: begin
                    v = int'(fgt) + $urandom_range(0, 3);
                    if (v > 31) v = 31;
                    fg_sense = 5'(v);
                end
                6: fr_sense = 5'($urandom_range(0, 31));
                7: begin
                    v = int'(frt) + $urandom_range(0, 3);
                    if (v > 31) v = 31;
                    fr_sense = 5'(v);
                end
                default: ;
            endcase
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fridge_thermostat.md
# fridge_thermostat

Closed-loop compressor controller that sits directly downstream of the fridge settings block. It consumes the stored fridge/freezer temperature setpoints and the compartment power bits, compares them against measured sensor codes with hysteresis, and drives a single shared compressor, two compartment dampers and a periodic defrost heater. Compressor protection comes from minimum-on and minimum-off timers measured in slow `tick` strobes.

## Interface
- `HYST`, 2: hysteresis in temperature codes.
- `MIN_ON`, 60: minimum compressor run time, in ticks.
- `MIN_OFF`, 120: minimum compressor rest time, in ticks.
- `DEFROST_INTERVAL`, 480: accumulated run ticks that trigger a defrost.
- `DEFROST_LEN`, 30: defrost heater duration, in ticks.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle timebase strobe.
- `fgp`, `frp` in 1 each: fridge/freezer compartment enable.
- `fgt`, `frt` in 5 each: fridge/freezer setpoint code.
- `fg_sense`, `fr_sense` in 5 each: measured temperature code. Unsigned; higher code means warmer.
- `comp_on` out 1: compressor drive.
- `fg_damper`, `fr_damper` out 1 each: compartment damper open.
- `defrost_on` out 1: defrost heater drive.
- `state` out 2: current FSM state, for debug.

## Operation
- **Per-channel demand latch:**
  - Set when `sense >= setpoint + HYST`. The sum is computed 6 bits wide, so there is no wrap; a setpoint of 31 with HYST 2 needs sense ≥ 33 and therefore never sets.
  - Cleared when `sense <= setpoint`.
  - Held in between.
  - Forced and held at 0 while the channel's power bit is 0.
- `any_dem` = `fg_dem | fr_dem`.
- FSM states: OFF_WAIT=0, IDLE=1, RUN=2, DEFROST=3.
- **OFF_WAIT:** `cnt` increments on each tick. Leave for IDLE on the tick where `cnt` reaches `MIN_OFF`.
- **IDLE:** move to RUN when `any_dem`. `cnt` is cleared on entry to RUN.
- **RUN:**
  - On each tick, `cnt` increments and `run_acc` increments. Both saturate, `run_acc` at `DEFROST_INTERVAL`.
  - When `cnt >= MIN_ON` and `run_acc == DEFROST_INTERVAL`, go to DEFROST. This has priority.
  - Otherwise, when `cnt >= MIN_ON` and `!any_dem`, go to OFF_WAIT.
  - Demand dropping before `MIN_ON` does not stop the compressor.
- **DEFROST:** `cnt` counts ticks. When it reaches `DEFROST_LEN`, go to OFF_WAIT and clear `run_acc`.
- `cnt` clears on every state change.
- **Outputs (Moore, decoded from the state register):**
  - `comp_on` = (state==RUN).
  - `fg_damper` = RUN & `fg_dem`.
  - `fr_damper` = RUN & `fr_dem`.
  - `defrost_on` = (state==DEFROST).
- Demand arriving during DEFROST or OFF_WAIT is held and served after the rest period expires.

## Timing
- **Reset:** state=OFF_WAIT, `cnt`=0, `run_acc`=0, demand latches 0, all outputs 0. The compressor therefore rests `MIN_OFF` ticks after power-up.
- Reset asserted mid-RUN or mid-DEFROST drops `comp_on` and `defrost_on` immediately, because the reset is asynchronous.
- **Latency:** a sense/setpoint change sampled at edge N updates the demand latch at edge N. The IDLE→RUN transition happens at edge N+1, so `comp_on` is high in the following cycle.
- Counters and timed transitions advance only on cycles where `tick` is 1. A tick coincident with a state change counts toward the old state's condition only.
- Power bit falling clears demand on the next edge. RUN still honours `MIN_ON`.
- Setpoint changes take effect in the next comparison cycle; no settling is required.

## Configuration
- **`THERMO_DEFROST_EN` defined:** the DEFROST state and `run_acc` behave as described above.
- **Undefined:**
  - `run_acc` is absent.
  - RUN never enters DEFROST.
  - `defrost_on` is tied to 0.
  - Encoding 3 is unreachable; if it is ever reached, the FSM goes to OFF_WAIT.

## Structure
- **Shared package `fridge_pkg`:**
  - `TEMP_W=5`.
  - The state enum `thermo_state_t` (OFF_WAIT, IDLE, RUN, DEFROST).
  - The counter width constant `TICK_CNT_W=16`.
- **Sub-module `thermo_channel`:** a demand latch with hysteresis compare, instantiated twice, one for fridge and one for freezer.
- **Top level:** the FSM, counters and output decode.

## Test plan
Bench parameters: `HYST`=2, `MIN_ON`=3, `MIN_OFF`=4, `DEFROST_INTERVAL`=10, `DEFROST_LEN`=2, `tick` every 4 clocks.

1. **Power-up rest:** release reset with `fgp`=1, `fgt`=10, `fg_sense`=15 → `comp_on` stays 0 for 4 ticks, then rises; `fg_damper`=1, `fr_damper`=0.
2. **Hysteresis band:** in IDLE, `fgt`=10, ramp `fg_sense` 10→11→12 → `comp_on` rises only at 12. Drop to 11 → `comp_on` stays on. Drop to 10 after `MIN_ON` is met → OFF_WAIT.
3. **Minimum run:** demand pulse lasting 1 tick → `comp_on` stays high exactly until `cnt`=3 ticks, then OFF_WAIT with a 4-tick rest.
4. **Defrost (`THERMO_DEFROST_EN`):** continuous freezer demand, `frt`=5, `fr_sense`=20 → after 10 run ticks, `comp_on`=0 and `defrost_on`=1 for 2 ticks, then a 4-tick rest, then RUN resumes. Without the macro, `comp_on` stays 1 indefinitely.
5. **Power drop:** `frp` falls during RUN at tick 1 → `fr_dem` clears next edge, `fr_damper`=0, compressor holds until tick 3, then OFF_WAIT.
6. **Async reset mid-DEFROST:** `rst_n` low between clock edges → `defrost_on` and `state` go to 0 and OFF_WAIT without waiting for a clock.
